// File: rtl/ysyx_22041412_lsu.sv
// rtl/ysyx_22041412_lsu.sv - MEM-stage load/store unit in front of the data SRAM
//
// Purpose: accepts one load/store at a time, drives the SRAM for exactly one
// issue cycle, waits RD_LAT cycles, captures the (already extended) read data
// and returns it to WB under a valid/ready handshake.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake from EX/MEM
//   req_addr/wdata/wen/func3/rd  request payload
//   resp_valid/resp_ready        response handshake to WB
//   resp_rdata/resp_rd/resp_err  response payload
//   mem_addr/wdata/wen/func3     SRAM request side
//   mem_rdata                    SRAM read data
//   lsu_stall                    holds upstream pipeline registers
//
// Optional feature macro: YSYX_22041412_LSU_MISALIGN_CHK_EN
//   defined   : misaligned requests bypass the SRAM and return resp_err = 1;
//               func3 111 also reports resp_err = 1
//   undefined : resp_err is tied to 0, all addresses are issued unchanged
module ysyx_22041412_lsu #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_wen,
  input  logic [2:0]            req_func3,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic [2:0]            mem_func3,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  lsu_stall
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [4:0] rd_q;
  logic       zero_q;   // result forced to 0 (store or invalid func3)
  logic       inv;

  assign inv       = (req_func3 == 3'b111);
  assign req_ready = (state == S_IDLE);
  // Stall must cover the accept cycle itself, before the state register moves.
  assign lsu_stall = (state != S_IDLE) | req_valid;

`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
  logic mis;
  logic mis_q;
  logic err_q;

  always_comb begin
    mis = 1'b0;
    case (req_func3[1:0])
      2'b01:   mis = (req_addr[0] != 1'b0);
      2'b10:   mis = (req_addr[1:0] != 2'b00);
      2'b11:   mis = (req_addr[2:0] != 3'b000);
      default: mis = 1'b0;
    endcase
  end
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      rd_q       <= 5'd0;
      zero_q     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wen    <= 1'b0;
      mem_func3  <= 3'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= 5'd0;
`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      resp_err   <= 1'b0;
`endif
    end else begin
      // Write enable is only ever high for the single ISSUE cycle.
      mem_wen <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rd_q   <= req_rd;
            zero_q <= req_wen | inv;
            state  <= S_ISSUE;
`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
            mis_q  <= mis;
            err_q  <= mis | inv;
            // A misaligned request never reaches the SRAM pins.
            if (!mis) begin
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              mem_func3 <= req_func3;
              mem_wen   <= req_wen & ~inv;
            end
`else
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            mem_func3 <= req_func3;
            mem_wen   <= req_wen & ~inv;
`endif
          end
        end
        S_ISSUE: begin
`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
          if (mis_q) begin
            // Misaligned: report straight away, one cycle after acceptance.
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_rd    <= rd_q;
            resp_err   <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt   <= 4'(RD_LAT);
            state <= S_WAIT;
          end
`else
          cnt   <= 4'(RD_LAT);
          state <= S_WAIT;
`endif
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            resp_valid <= 1'b1;
            resp_rdata <= zero_q ? '0 : mem_rdata;
            resp_rd    <= rd_q;
`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
            resp_err   <= err_q;
`endif
            state      <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
            resp_err   <= 1'b0;
`endif
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// tb/tb_ysyx_22041412_lsu.sv - directed self-checking bench for ysyx_22041412_lsu
module tb_ysyx_22041412_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wen, resp_ready;
  logic [63:0] req_addr, req_wdata, mem_rdata;
  logic [2:0]  req_func3;
  logic [4:0]  req_rd;

  logic        req_ready, resp_valid, resp_err, mem_wen, lsu_stall;
  logic [63:0] resp_rdata, mem_addr, mem_wdata;
  logic [4:0]  resp_rd;
  logic [2:0]  mem_func3;

  logic        req_ready_3, resp_valid_3, resp_err_3, mem_wen_3, lsu_stall_3;
  logic [63:0] resp_rdata_3, mem_addr_3, mem_wdata_3;
  logic [4:0]  resp_rd_3;
  logic [2:0]  mem_func3_3;

  int errors = 0;
  int checks = 0;
  int pulses, bad;

  always #5 clk = ~clk;

  ysyx_22041412_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wen(req_wen), .req_func3(req_func3), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata), .lsu_stall(lsu_stall)
  );

  ysyx_22041412_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wen(req_wen), .req_func3(req_func3), .req_rd(req_rd),
    .resp_valid(resp_valid_3), .resp_ready(resp_ready), .resp_rdata(resp_rdata_3),
    .resp_rd(resp_rd_3), .resp_err(resp_err_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_wen(mem_wen_3),
    .mem_func3(mem_func3_3), .mem_rdata(mem_rdata), .lsu_stall(lsu_stall_3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input string tag);
    for (int i = 0; i < 30 && resp_valid !== 1'b1; i++) tick();
    chk(tag, resp_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_func3 = 3'd0; req_rd = 5'd0;
    mem_rdata = 64'h1122334455667788;
    tick(); tick();

    // Reset state
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_wen", mem_wen, 1'b0);
    chk("rst_stall", lsu_stall, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    rst_n = 1'b1;
    tick();

    // Aligned ld, RD_LAT=1: resp_valid 3 edges after accept
    req_valid = 1'b1; req_addr = 64'h80000008; req_func3 = 3'b011;
    req_rd = 5'd5; req_wen = 1'b0; req_wdata = 64'hFFFF;
    #1;
    chk("ld_stall_comb", lsu_stall, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("ld_issue_addr", mem_addr, 64'h80000008);
    chk("ld_issue_func3", mem_func3, 3'b011);
    chk("ld_issue_wen", mem_wen, 1'b0);
    chk("ld_req_ready_busy", req_ready, 1'b0);
    chk("ld_stall_busy", lsu_stall, 1'b1);
    tick();
    chk("ld_valid_e1", resp_valid, 1'b0);
    tick();
    chk("ld_valid_e2", resp_valid, 1'b0);
    chk("ld_wait_wen", mem_wen, 1'b0);
    tick();
    chk("ld_valid_e3", resp_valid, 1'b1);
    chk("ld_rdata", resp_rdata, 64'h1122334455667788);
    chk("ld_rd", resp_rd, 5'd5);
    chk("ld_err", resp_err, 1'b0);
    resp_ready = 1'b1;
    tick();
    chk("ld_done_valid", resp_valid, 1'b0);
    chk("ld_done_ready", req_ready, 1'b1);
    resp_ready = 1'b0;

    // sw: one wen pulse, zero result, stall until handshake
    req_valid = 1'b1; req_addr = 64'h80000010; req_wdata = 64'hDEADBEEF;
    req_func3 = 3'b010; req_wen = 1'b1; req_rd = 5'd7;
    tick();
    req_valid = 1'b0; req_wen = 1'b0;
    pulses = mem_wen ? 1 : 0;
    chk("sw_wen", mem_wen, 1'b1);
    chk("sw_addr", mem_addr, 64'h80000010);
    chk("sw_wdata", mem_wdata, 64'hDEADBEEF);
    chk("sw_func3", mem_func3, 3'b010);
    bad = 0;
    for (int i = 0; i < 20 && resp_valid !== 1'b1; i++) begin
      tick();
      if (mem_wen) pulses++;
      if (!lsu_stall) bad++;
    end
    chk("sw_resp_valid", resp_valid, 1'b1);
    chk("sw_rdata_zero", resp_rdata, 64'h0);
    chk("sw_rd", resp_rd, 5'd7);
    chk("sw_wen_pulses", pulses, 1);
    chk("sw_stall_gap", bad, 0);
    tick();
    chk("sw_stall_resp", lsu_stall, 1'b1);
    resp_ready = 1'b1;
    tick();
    chk("sw_stall_done", lsu_stall, 1'b0);
    resp_ready = 1'b0;

    // Back-pressure
    req_valid = 1'b1; req_addr = 64'h80000020; req_func3 = 3'b011; req_rd = 5'd9;
    mem_rdata = 64'hA5A5000012345678;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("bp_valid", resp_valid, 1'b1);
    chk("bp_rdata", resp_rdata, 64'hA5A5000012345678);
    mem_rdata = 64'h0;
    req_valid = 1'b1; req_addr = 64'h80000040; req_rd = 5'd10;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_rdata !== 64'hA5A5000012345678 ||
          req_ready !== 1'b0 || mem_addr !== 64'h80000020) bad++;
    end
    chk("bp_hold", bad, 0);
    resp_ready = 1'b1;
    tick();
    chk("bp_release_valid", resp_valid, 1'b0);
    chk("bp_release_ready", req_ready, 1'b1);
    chk("bp_not_yet_accepted", mem_addr, 64'h80000020);
    resp_ready = 1'b0;
    tick();
    chk("bp_new_accepted", mem_addr, 64'h80000040);
    chk("bp_new_busy", req_ready, 1'b0);
    req_valid = 1'b0;
    wait_resp("bp_new_resp");
    chk("bp_new_rd", resp_rd, 5'd10);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // func3 111 store: no wen, zero result
    mem_rdata = 64'hFFFFFFFFFFFFFFFF;
    req_valid = 1'b1; req_addr = 64'h80000030; req_wdata = 64'h55;
    req_func3 = 3'b111; req_wen = 1'b1; req_rd = 5'd3;
    tick();
    req_valid = 1'b0; req_wen = 1'b0;
    pulses = mem_wen ? 1 : 0;
    for (int i = 0; i < 20 && resp_valid !== 1'b1; i++) begin
      tick();
      if (mem_wen) pulses++;
    end
    chk("inv_resp_valid", resp_valid, 1'b1);
    chk("inv_wen_pulses", pulses, 0);
    chk("inv_rdata", resp_rdata, 64'h0);
`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
    chk("inv_err", resp_err, 1'b1);
`else
    chk("inv_err", resp_err, 1'b0);
`endif
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Misaligned lh at 0x80000001
    mem_rdata = 64'hFFFFFFFFFFFFFF80;
    req_valid = 1'b1; req_addr = 64'h80000001; req_func3 = 3'b001;
    req_wen = 1'b0; req_rd = 5'd4;
    tick();
    req_valid = 1'b0;
`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
    chk("mis_wen", mem_wen, 1'b0);
    chk("mis_no_addr", mem_addr, 64'h80000030);
    tick();
    chk("mis_valid", resp_valid, 1'b1);
    chk("mis_err", resp_err, 1'b1);
    chk("mis_rdata", resp_rdata, 64'h0);
`else
    chk("mis_addr", mem_addr, 64'h80000001);
    chk("mis_func3", mem_func3, 3'b001);
    tick(); tick();
    chk("mis_valid_early", resp_valid, 1'b0);
    tick();
    chk("mis_valid", resp_valid, 1'b1);
    chk("mis_err", resp_err, 1'b0);
    chk("mis_rdata", resp_rdata, 64'hFFFFFFFFFFFFFF80);
`endif
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset during WAIT of a store
    req_valid = 1'b1; req_addr = 64'h80000050; req_wdata = 64'h1234;
    req_func3 = 3'b011; req_wen = 1'b1; req_rd = 5'd6;
    tick();
    req_valid = 1'b0; req_wen = 1'b0;
    tick();
    chk("rstw_pre_addr", mem_addr, 64'h80000050);
    rst_n = 1'b0;
    #1;
    chk("rstw_addr", mem_addr, 64'h0);
    chk("rstw_wdata", mem_wdata, 64'h0);
    chk("rstw_wen", mem_wen, 1'b0);
    chk("rstw_ready", req_ready, 1'b1);
    chk("rstw_stall", lsu_stall, 1'b0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid !== 1'b0) bad++;
    end
    chk("rstw_no_resp", bad, 0);
    chk("rstw_ready_after", req_ready, 1'b1);

    // Back-to-back loads on the RD_LAT=3 instance
    mem_rdata = 64'hCAFE;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 64'h80001000; req_func3 = 3'b011; req_rd = 5'd1;
    tick();
    req_addr = 64'h80001008; req_rd = 5'd2;
    chk("b2b_first_addr", mem_addr_3, 64'h80001000);
    bad = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("b2b_valid_%0d", k), resp_valid_3, (k == 5));
      chk($sformatf("b2b_ready_%0d", k), req_ready_3, (k == 6));
      if (k == 5) begin
        chk("b2b_rdata", resp_rdata_3, 64'hCAFE);
        chk("b2b_rd", resp_rd_3, 5'd1);
      end
      if (mem_addr_3 !== 64'h80001000) bad++;
    end
    chk("b2b_no_overlap", bad, 0);
    tick();
    chk("b2b_second_addr", mem_addr_3, 64'h80001008);
    chk("b2b_second_busy", req_ready_3, 1'b0);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("b2b_second_rd", resp_rd_3, 5'd2);
    chk("b2b_second_idle", req_ready_3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_lsu.md
Name: ysyx_22041412_lsu

Overview:
Load/store unit sitting directly upstream of the data SRAM (ysyx_22041412_sram) in the MEM stage. Accepts one memory request at a time from EX/MEM over a valid/ready handshake and drives the SRAM address, write data, write enable and func3. It waits a fixed read latency, captures the already sign/zero-extended SRAM read data, and returns it to WB over a second valid/ready handshake. It raises a pipeline stall while a transaction is outstanding.

Parameters:
ADDR_WIDTH, 64, request and SRAM address width
DATA_WIDTH, 64, data width
RD_LAT, 1, cycles from SRAM address issue to valid mem_rdata (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present from EX/MEM
req_ready  out  1  LSU can accept a request
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
req_wen  in  1  1 = store, 0 = load
req_func3  in  3  RV64 load/store func3
req_rd  in  5  destination register tag
resp_valid  out  1  result available to WB
resp_ready  in  1  WB accepts result
resp_rdata  out  DATA_WIDTH  load result (0 for stores)
resp_rd  out  5  tag of the completed request
resp_err  out  1  misaligned access (only when the optional feature is enabled)
mem_addr  out  ADDR_WIDTH  to SRAM addr
mem_wdata  out  DATA_WIDTH  to SRAM wdata
mem_wen  out  1  to SRAM wen, one-cycle pulse
mem_func3  out  3  to SRAM func3
mem_rdata  in  DATA_WIDTH  from SRAM rdata, already extended
lsu_stall  out  1  holds upstream pipeline registers

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All state transitions and output registers update on the rising edge of clk.
- Reset (async, rst_n=0):
  - state = IDLE; all outputs 0 except req_ready = 1.
  - Reset mid-transaction abandons the transaction. No resp_valid follows; mem_wen drops to 0 immediately.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch addr, wdata, wen, func3, rd; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr/mem_wdata/mem_func3 driven from the latched values; mem_wen = latched wen.
  - Latency counter loads RD_LAT; go to WAIT.
- WAIT:
  - mem_addr/mem_func3 held stable; mem_wen = 0.
  - Counter decrements each cycle.
  - When the counter reaches 0: capture mem_rdata for loads, or 0 for stores; go to RESP.
- Latency: req accepted at edge N; resp_valid asserted at edge N+2+RD_LAT.
- RESP:
  - resp_valid = 1; resp_rdata/resp_rd stable.
  - On resp_ready, go to IDLE.
  - Back-pressure: resp_valid stays asserted and data stays stable for any number of cycles until resp_ready.
- req_ready = 1 only in IDLE. No request overlaps another; a req_valid arriving in any other state is not accepted.
- lsu_stall = 1 whenever state != IDLE, and combinationally in IDLE when req_valid = 1.
- Outside ISSUE, mem_wen = 0 under all conditions. A store produces exactly one wen pulse.
- func3 111 (invalid): treated as a load with 0 result and no mem_wen. resp_err = 1 if the optional feature is enabled.
- The address is passed through unmodified. No wrap or arithmetic is applied.

Optional Feature:
- Macro: YSYX_22041412_LSU_MISALIGN_CHK_EN.
- With the macro defined:
  - The latched request is checked for misalignment:
    - func3[1:0]=01: addr[0] != 0
    - func3[1:0]=10: addr[1:0] != 0
    - func3[1:0]=11: addr[2:0] != 0
  - A misaligned request skips ISSUE/WAIT: no mem_wen, no SRAM access.
  - It goes directly IDLE→RESP one cycle after acceptance, with resp_err = 1 and resp_rdata = 0.
- Without the macro: resp_err is tied to 0 and all addresses are issued unchanged.

Test Plan:
- Reset, then aligned ld: addr=0x80000008, func3=011, RD_LAT=1, mem_rdata=0x1122334455667788 -> resp_valid at accept+3 edges; resp_rdata=0x1122334455667788; resp_rd echoed; mem_wen stays 0 throughout.
- sw: addr=0x80000010, wdata=0xDEADBEEF, func3=010 -> exactly one mem_wen pulse carrying that addr/wdata/func3; resp_rdata=0; lsu_stall high from acceptance until the resp handshake.
- Back-pressure: load completes with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held constant; req_ready=0; a new req_valid is not accepted until 1 cycle after resp_ready.
- Back-to-back loads with resp_ready=1 and RD_LAT=3 -> each load takes 6 cycles from acceptance to IDLE; no overlap of SRAM addresses.
- Assert rst_n=0 during WAIT of a store -> all outputs clear immediately; req_ready=1 after release; no resp_valid is produced.
- With MISALIGN_CHK_EN, lh at addr=0x80000001 -> no mem_wen; resp_valid 1 cycle after acceptance; resp_err=1; resp_rdata=0. Without the macro, the same request is issued to the SRAM and resp_err=0.
